// File: rtl/accel_core_pkg.sv
// Shared types and constants for the accelerator core: register-map word width,
// stream buffer depth and the status bundle the control map mirrors.
package accel_core_pkg;

  localparam int MMAP_WIDTH = 32;
  localparam int BUFF_DEPTH = 16;

  typedef logic [MMAP_WIDTH-1:0] buff_word_t;

  // Consumed by the control map as a single read-only field.
  typedef struct packed {
    logic full;
    logic empty;
    logic overflow;
  } buff_status_t;

  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == DROP_CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/accel_core_buff_ram.sv
// Simple dual-port storage for accel_core_buff: one synchronous write port and
// one asynchronous read port, kept apart from the pointer/flag logic.
module accel_core_buff_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy lives in the pointers/count, so the
  // array maps onto plain RAM cells without a clear path.
  always_ff @(posedge aclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/accel_core_buff.sv
// Stream FIFO between the control register map and the core datapath:
// strobe writer, valid/ready first-word-fall-through reader, sticky overflow.
// Optional build macro ACCEL_CORE_BUFF_DROP_CNT_EN adds a saturating drop_cnt.
module accel_core_buff
  import accel_core_pkg::*;
#(
  parameter int DATA_W = $bits(buff_word_t),
  parameter int DEPTH  = BUFF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  input  logic              ovf_clr,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overflow
`ifdef ACCEL_CORE_BUFF_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             overflow_q;
  buff_status_t     status;

  logic pop;
  logic push;
  logic ovf_set;

  // Flags come only from registered state so the control map sees no
  // combinational path from the handshake inputs.
  assign status.full     = (count_q == DEPTH_CNT);
  assign status.empty    = (count_q == '0);
  assign status.overflow = overflow_q;

  assign full     = status.full;
  assign empty    = status.empty;
  assign overflow = status.overflow;
  assign rd_valid = !status.empty;
  assign count    = count_q;

  // A pop at full frees the slot the same-cycle push lands in; flush
  // discards the push without counting it as a drop.
  assign pop     = rd_valid && rd_ready;
  assign push    = wr_en && (!status.full || pop) && !flush;
  assign ovf_set = wr_en && status.full && !pop && !flush;

  // NOTE: every combinational output gets a default first, so no path can
  // leave count_d unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      overflow_q <= 1'b0;
    end else if (ovf_set) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef ACCEL_CORE_BUFF_DROP_CNT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= ovf_set ? 16'd1 : 16'd0;
    end else if (ovf_set) begin
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end
`endif

  accel_core_buff_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .aclk  (aclk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_accel_core_buff.sv
// Self-checking bench for accel_core_buff: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_accel_core_buff;

  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        flush;
  logic        ovf_clr;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
`ifdef ACCEL_CORE_BUFF_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 aclk = ~aclk;

  accel_core_buff dut (
    .aclk     (aclk),
    .areset   (areset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
`ifdef ACCEL_CORE_BUFF_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: contents as a queue plus the sticky bit and drop tally.
  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_dcnt;
  logic [31:0] got[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_dcnt = 0;
  endtask

  task automatic model_apply(input logic we, input logic [31:0] wd, input logic rr,
                             input logic fl, input logic oc);
    bit pop_now;
    bit drop;
    pop_now = (mq.size() > 0) && rr;
    drop    = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop_now) void'(mq.pop_front());
      if (we) begin
        if (mq.size() < DEPTH) mq.push_back(wd);
        else drop = 1'b1;
      end
    end
    if (drop)    m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    if (oc)                         m_dcnt = drop ? 1 : 0;
    else if (drop && m_dcnt < 65535) m_dcnt++;
  endtask

  task automatic compare_state();
    check("count",    32'(count),    32'(mq.size()));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("full",     32'(full),     32'(mq.size() == DEPTH));
    check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) check("rd_data", rd_data, mq[0]);
`ifdef ACCEL_CORE_BUFF_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
`endif
  endtask

  // One clock: drive at edge+1, record any handshake, advance model, sample.
  task automatic cycle(input logic we, input logic [31:0] wd, input logic rr,
                       input logic fl, input logic oc);
    wr_en    = we;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    ovf_clr  = oc;
    if (rd_valid && rr && !fl) got.push_back(rd_data);
    model_apply(we, wd, rr, fl, oc);
    @(posedge aclk);
    #1;
    compare_state();
  endtask

  typedef struct {
    logic        we;
    logic [31:0] wd;
    logic        rr;
    logic        fl;
    logic        oc;
    int          exp_cnt;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int next;
    int guard;

    vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001, 1'b0};
    vecs[1] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1, 32'hA5A5_0001, 1'b0};
    vecs[2] = '{1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1, 32'h1111_1111, 1'b0};
    vecs[3] = '{1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 2, 32'h1111_1111, 1'b0};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1, 32'h2222_2222, 1'b0};
    vecs[5] = '{1'b1, 32'h3333_3333, 1'b1, 1'b1, 1'b0, 0, 32'h0,         1'b0};
    vecs[6] = '{1'b1, 32'h4444_4444, 1'b1, 1'b0, 1'b0, 1, 32'h4444_4444, 1'b0};
    vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 0, 32'h0,         1'b0};

    areset = 1'b1; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    model_reset();
    @(posedge aclk);
    #1;
    check("reset_empty",    32'(empty),    32'd1);
    check("reset_full",     32'(full),     32'd0);
    check("reset_count",    32'(count),    32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Directed vector table
    foreach (vecs[i]) begin
      cycle(vecs[i].we, vecs[i].wd, vecs[i].rr, vecs[i].fl, vecs[i].oc);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_cnt != 0));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      if (vecs[i].exp_cnt != 0) check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
    end

    // Fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("ovf_full",  32'(full),     32'd1);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd16);
`ifdef ACCEL_CORE_BUFF_DROP_CNT_EN
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", rd_data, 32'hC000_0000 + i);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'd0);

    // Push with simultaneous pop at full
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    check("pp_count", 32'(count),    32'd16);
    check("pp_full",  32'(full),     32'd1);
    check("pp_ovf",   32'(overflow), 32'd0);
    got.delete();
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("pp_pops", 32'(got.size()), 32'd16);
    if (got.size() == 16) begin
      check("pp_first", got[0],  32'hD000_0001);
      check("pp_16th",  got[15], 32'h0000_1234);
    end

    // 40 words across pointer wrap with random backpressure
    got.delete();
    next = 0;
    guard = 0;
    while ((next < 40 || mq.size() > 0) && guard < 400) begin
      logic we;
      we = (next < 40) && (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      cycle(we, 32'(next), logic'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (we) next++;
      check("wrap_count_le16", 32'(count <= 5'd16), 32'd1);
      guard++;
    end
    check("wrap_received", 32'(got.size()), 32'd40);
    foreach (got[i]) check("wrap_order", got[i], 32'(i));

    // Flush with push and pop in the same cycle, overflow held
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hE000_0000 + i, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hF000_0000 + i, 1'b0, 1'b0, 1'b0);
    check("fl_pre_count", 32'(count), 32'd5);
    cycle(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 1'b0);
    check("fl_count", 32'(count),    32'd0);
    check("fl_empty", 32'(empty),    32'd1);
    check("fl_ovf",   32'(overflow), 32'd1);
    cycle(1'b1, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
    check("fl_next_data", rd_data, 32'h0000_0077);
`ifdef ACCEL_CORE_BUFF_DROP_CNT_EN
    check("fl_keeps_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Clear and drop in the same cycle: set wins
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 32'h5000_0000 + i, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h6666_6666, 1'b0, 1'b0, 1'b1);
    check("clr_drop_ovf", 32'(overflow), 32'd1);
`ifdef ACCEL_CORE_BUFF_DROP_CNT_EN
    check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Asynchronous reset mid-operation
    areset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_count", 32'(count),    32'd0);
    check("mid_rst_empty", 32'(empty),    32'd1);
    check("mid_rst_full",  32'(full),     32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_ovf",   32'(overflow), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(logic'($urandom_range(0, 2) != 0), $urandom, logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 40) == 0), logic'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
